// File: rtl/lut_cluster_cfg.sv
// Configurable LUT cluster: N_TILES K-input LUT tiles with routing muxes and optional
// output registers, loaded from a word-serial bitstream that is checked by an XOR checksum.

module lut_tile #(
    parameter int LUT_K     = 5,
    parameter int N_IN      = 12,
    parameter int N_TILES   = 8,
    parameter int SEL_W     = 5,
    parameter int TILE_BITS = 58
) (
    input  logic [TILE_BITS-1:0] cfg,
    input  logic [N_IN-1:0]      in,
    input  logic [N_TILES-1:0]   q,
    output logic                 lut,
    output logic                 mode
);
    localparam int SRC = N_IN + N_TILES;
    localparam int TT  = 1 << LUT_K;

    logic [SRC-1:0]                src;
    logic [TT-1:0]                 tt;
    logic [LUT_K-1:0][SEL_W-1:0]   sel;
    logic [LUT_K-1:0]              idx;

    assign src  = {q, in};
    assign tt   = cfg[TT-1:0];
    assign mode = cfg[TT];

    // Select codes beyond the source list read as constant 0.
    always_comb begin
        idx = '0;
        for (int m = 0; m < LUT_K; m++) begin
            sel[m] = cfg[TT+1+m*SEL_W +: SEL_W];
            if (32'(sel[m]) < SRC) idx[m] = src[sel[m]];
        end
    end

    assign lut = tt[idx];
endmodule

module lut_cluster_cfg #(
    parameter int N_TILES = 8,
    parameter int LUT_K   = 5,
    parameter int N_IN    = 12,
    parameter int CFG_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CFG_W-1:0]   cfg_data,
    output logic               cfg_done,
    output logic               cfg_error,
    input  logic [N_IN-1:0]    in,
    output logic [N_TILES-1:0] out
);
    localparam int SRC       = N_IN + N_TILES;
    localparam int SEL_W     = $clog2(SRC);
    localparam int TILE_BITS = (1 << LUT_K) + 1 + LUT_K * SEL_W;
    localparam int TOTAL     = N_TILES * TILE_BITS;
    localparam int WORDS     = (TOTAL + CFG_W - 1) / CFG_W;
    localparam int CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] ERROR = 3'd4;

    logic [2:0]                          state;
    logic [CNT_W-1:0]                    cnt;
    logic [CFG_W-1:0]                    csum;
    logic [N_TILES-1:0][TILE_BITS-1:0]   cfg_q;
    logic [N_TILES-1:0]                  q, lut, mode;
    logic                                accept, run;

    assign run       = (state == RUN);
    assign cfg_ready = (state == LOAD) || (state == CHECK);
    assign cfg_done  = run;
    assign cfg_error = (state == ERROR);
    assign accept    = cfg_valid && cfg_ready;

    lut_tile #(
        .LUT_K(LUT_K), .N_IN(N_IN), .N_TILES(N_TILES), .SEL_W(SEL_W), .TILE_BITS(TILE_BITS)
    ) u_tile [N_TILES-1:0] (
        .cfg (cfg_q),
        .in  (in),
        .q   (q),
        .lut (lut),
        .mode(mode)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            csum  <= '0;
            cfg_q <= '0;
        end else if (cfg_start) begin
            // A restart wins over any word offered in the same cycle.
            state <= LOAD;
            cnt   <= '0;
            csum  <= '0;
        end else begin
            case (state)
                LOAD: if (accept) begin
                    // Padding bits past the last tile field are dropped.
                    for (int i = 0; i < WORDS; i++)
                        if (cnt == CNT_W'(i))
                            for (int k = 0; k < CFG_W; k++)
                                if (i * CFG_W + k < TOTAL)
                                    cfg_q[(i*CFG_W+k)/TILE_BITS][(i*CFG_W+k)%TILE_BITS] <= cfg_data[k];
                    csum <= csum ^ cfg_data;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WORDS - 1)) state <= CHECK;
                end
                CHECK: if (accept) state <= (cfg_data == csum) ? RUN : ERROR;
                default: state <= state;
            endcase
        end
    end

    // Tile registers only run in RUN; feedback always comes from here.
    always_ff @(posedge clock) begin
        if (reset || !run) q <= '0;
        else               q <= lut;
    end

    always_comb begin
        out = '0;
        if (run)
            for (int j = 0; j < N_TILES; j++)
                out[j] = mode[j] ? q[j] : lut[j];
    end
endmodule

// File: doc/lut_cluster_cfg.md
# lut_cluster_cfg

Parametrised configurable logic cluster: N_TILES K-input LUT tiles, each with an optional output register and a per-input routing multiplexer fed from primary inputs and registered tile feedback. It also contains an on-chip configuration loader that accepts a word-serial bitstream over a valid/ready handshake and checks it against an XOR checksum. The fabric runs only after a successful load. It is the successor to the fixed 5-LUT tile and 4x4 switch-box fabric, and adds real configuration load, reset, and a routing width that scales with the parameters.

## Interface
- N_TILES, 8, number of LUT tiles (= out width)
- LUT_K, 5, LUT inputs per tile
- N_IN, 12, primary inputs
- CFG_W, 8, configuration word width
- Derived: SRC = N_IN+N_TILES; SEL_W = clog2(SRC); TILE_BITS = 2^LUT_K + 1 + LUT_K*SEL_W; TOTAL = N_TILES*TILE_BITS; WORDS = ceil(TOTAL/CFG_W). Defaults: SEL_W=5, TILE_BITS=58, TOTAL=464, WORDS=58.

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cfg_start  in  1  pulse; begins (or restarts) a load
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts a word this cycle
- cfg_data  in  CFG_W  bitstream word
- cfg_done  out  1  high while in RUN
- cfg_error  out  1  high while in ERROR
- in  in  N_IN  primary inputs
- out  out  N_TILES  tile outputs

## Operation
- Config vector C is WORDS*CFG_W bits. The i-th accepted data word is written to C[i*CFG_W +: CFG_W]. Padding bits above TOTAL are ignored.
- Tile j field base is b = j*TILE_BITS:
  - C[b +: 2^K] is the truth table. Entry index = {x[K-1],...,x[0]}.
  - C[b+2^K] is mode: 0 = combinational, 1 = registered.
  - LUT input m select = C[b+2^K+1+m*SEL_W +: SEL_W].
- Select value decoding:
  - s < N_IN → in[s]
  - N_IN ≤ s < SRC → q[s-N_IN] (registered output of that tile)
  - s ≥ SRC → constant 0
- Feedback is always taken from q, never from combinational LUT output. No combinational loops are possible.
- lut[j] = truth_table[index]. q[j] loads lut[j] each edge in RUN. q[j] is forced to 0 in every other state.
- out[j] = (state==RUN) ? (mode ? q[j] : lut[j]) : 0.
- FSM states IDLE, LOAD, CHECK, RUN, ERROR:
  - reset → IDLE; C, q, word counter and checksum all clear to 0.
  - cfg_start in any state → LOAD next cycle; counter and checksum cleared. C is not cleared; it is overwritten as words arrive.
  - LOAD: cfg_ready=1. Each valid&ready stores a word, checksum ^= word, counter++. The accept with counter==WORDS-1 → CHECK.
  - CHECK: cfg_ready=1. On accept, compare word with checksum: equal → RUN, else → ERROR.
  - RUN and ERROR hold until cfg_start or reset. IDLE holds until cfg_start.
- cfg_start has priority over a simultaneous handshake; that word is discarded.
- cfg_ready=0 in IDLE, RUN and ERROR. cfg_valid is ignored there.

## Timing
- Reset values: cfg_ready=0, cfg_done=0, cfg_error=0, out=0.
- cfg_start sampled at edge t → cfg_ready=1 from cycle t+1.
- Checksum accepted at edge t → cfg_done=1 (or cfg_error=1) from cycle t+1. Combinational tiles are live in cycle t+1.
- q update timing:
  - First q update occurs at the end of the first RUN cycle.
  - A registered tile shows 0 in the first RUN cycle.
- in→out latency: 0 cycles in combinational mode, 1 cycle in registered mode.
- cfg_start during RUN → out=0 and cfg_done=0 from the next cycle.
- Minimum load is WORDS+1 handshake cycles (59 at defaults). Gaps in cfg_valid are allowed.

## Test plan
- Reset: assert reset 2 cycles with random in → out=0, cfg_ready=0, cfg_done=0, cfg_error=0; cfg_valid ignored.
- AND5: tile0 TT=0x80000000, selects 0..4, mode 0, all other tiles zero, correct checksum → cfg_done=1 one cycle after checksum. in=0x01F → out[0]=1 same cycle; in=0x01E → out[0]=0.
- Toggler: tile1 TT=0x00000001, mode 1, sel0=13, sel1..4=31 → out[1] = 0,1,0,1... starting at the first RUN cycle.
- Bad checksum: valid stream with last word XOR 0x01 → cfg_error=1, cfg_done=0, out=0, cfg_ready=0. A new cfg_start plus a correct stream → cfg_done=1.
- Backpressure/abort: random cfg_valid gaps, then cfg_start after 20 words, then a full correct stream → exactly 59 accepts counted, cfg_done=1, and AND5 behaviour correct.
- Reset mid-load after 30 words → IDLE, cfg_ready=0 next cycle. A subsequent full load behaves identically to one from power-up.
